// File: rtl/mmu_dcache_pkg.sv
// rtl/mmu_dcache_pkg.sv - shared types for the MMU-side D$ responder
package mmu_dcache_pkg;

  typedef enum logic [2:0] {
    OPC_NOP      = 3'd0,
    OPC_LOAD     = 3'd1,
    OPC_STORE    = 3'd2,
    OPC_ATOMIC   = 3'd3,
    OPC_PREFETCH = 3'd4
  } e1_dcache_opc_t;

  localparam int PERM_READ    = 0;
  localparam int PERM_WRITE   = 1;
  localparam int PERM_DIRTY   = 2;
  localparam int PERM_POLICY  = 3;
  localparam int PERM_CLUSTER = 4;

  // vpn is stored at the widest supported width so the struct is VA_W independent
  localparam int VPN_MAX_W = 52;
  localparam int PPN_W     = 10;

  typedef struct packed {
    logic                 valid;
    logic [VPN_MAX_W-1:0] vpn;
    logic [PPN_W-1:0]     ppn;
    logic [4:0]           perm;
  } tlb_entry_t;

  // listed from highest to lowest priority
  typedef enum logic [2:0] {
    TRAP_NONE,
    TRAP_DMISALIGN,
    TRAP_DSYSERROR,
    TRAP_NOMAPPING,
    TRAP_PROTECTION,
    TRAP_WRITETOCLEAN,
    TRAP_ATOMICTOCLEAN
  } trap_e;

  function automatic logic size_legal(input logic [3:0] size);
    case (size)
      4'd1, 4'd2, 4'd4, 4'd8: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mmu_dcache_tlb.sv
// rtl/mmu_dcache_tlb.sv - fully associative data TLB with parallel compare
module mmu_dcache_tlb
  import mmu_dcache_pkg::*;
#(
  parameter int TLB_ENTRIES = 4,
  parameter int VA_W        = 41,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [VA_W-13:0]  i_wr_vpn,
  input  logic [PPN_W-1:0]  i_wr_ppn,
  input  logic [4:0]        i_wr_perm,
  input  logic              i_inval_all,
  input  logic [VA_W-13:0]  i_lookup_vpn,
  output logic              o_hit,
  output logic              o_multi_hit,
  output logic [PPN_W-1:0]  o_ppn,
  output logic [4:0]        o_perm
);

  tlb_entry_t             r_entry [TLB_ENTRIES];
  logic [TLB_ENTRIES-1:0] w_match;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TLB_ENTRIES; i++) r_entry[i] <= '0;
    end else if (i_inval_all) begin
      for (int i = 0; i < TLB_ENTRIES; i++) r_entry[i].valid <= 1'b0;
    end else if (i_wr_en) begin
      r_entry[i_wr_idx] <= '{valid: 1'b1, vpn: VPN_MAX_W'(i_wr_vpn),
                             ppn: i_wr_ppn, perm: i_wr_perm};
    end
  end

  // OR-merge of matching entries; only meaningful when exactly one matches
  always_comb begin
    w_match = '0;
    o_ppn   = '0;
    o_perm  = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      w_match[i] = r_entry[i].valid && (r_entry[i].vpn == VPN_MAX_W'(i_lookup_vpn));
      if (w_match[i]) begin
        o_ppn  = o_ppn | r_entry[i].ppn;
        o_perm = o_perm | r_entry[i].perm;
      end
    end
  end

  assign o_hit       = |w_match;
  assign o_multi_hit = (w_match & (w_match - TLB_ENTRIES'(1))) != '0;

endmodule

// File: rtl/mmu_dcache_resp.sv
// rtl/mmu_dcache_resp.sv - E1 request acceptance, DTLB translation, trap decode
// and the registered E2 response with D$ E3 stall freeze
module mmu_dcache_resp
  import mmu_dcache_pkg::*;
#(
  parameter int TLB_ENTRIES = 4,
  parameter int VA_W        = 41
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           e1_dcache_req_m,
  input  logic [VA_W-1:0]                e1_dcache_virt_addr_m,
  input  logic [3:0]                     e1_dcache_size_m,
  input  e1_dcache_opc_t                 e1_dcache_opc_i_m,
  input  logic                           dcache_e1_grant_i_s,
  input  logic                           dcache_second_acc_d_i_s,
  input  logic                           dcache_e3_stall_i_s,
  input  logic                           tlb_wr_en,
  input  logic [$clog2(TLB_ENTRIES)-1:0] tlb_wr_idx,
  input  logic [VA_W-13:0]               tlb_wr_vpn,
  input  logic [9:0]                     tlb_wr_ppn,
  input  logic [4:0]                     tlb_wr_perm,
  input  logic                           tlb_inval_all,
  output logic                           e2_stall_m,
  output logic [21:12]                   e2_dcache_phys_addr_m,
  output logic                           e2_dcache_cluster_per_acc_m,
  output logic                           e2_dcache_policy_m,
  output logic                           e2_non_trapping_id_cancel_o,
  output logic [1:0]                     e2_trap_nomapping_o,
  output logic [1:0]                     e2_trap_protection_o,
  output logic [1:0]                     e2_trap_writetoclean_o,
  output logic [1:0]                     e2_trap_atomictoclean_o,
  output logic [1:0]                     e2_trap_dsyserror_o,
  output logic                           e2_trap_dmisalign_o
);

  typedef struct packed {
    logic       valid;
    logic [9:0] pa;
    logic       policy;
    logic       cluster;
    logic       cancel;
    logic [1:0] nomap;
    logic [1:0] prot;
    logic [1:0] w2c;
    logic [1:0] a2c;
    logic [1:0] sys;
    logic       mis;
  } e2_t;

  e2_t            r_e2;
  e2_t            w_e2_next;
  logic           w_hit;
  logic           w_multi_hit;
  logic [9:0]     w_ppn;
  logic [4:0]     w_perm;
  logic           w_misalign;
  logic           w_accept;
  trap_e          w_trap;
  e1_dcache_opc_t w_opc;

  assign w_opc = e1_dcache_opc_i_m;

  mmu_dcache_tlb #(.TLB_ENTRIES(TLB_ENTRIES), .VA_W(VA_W)) u_tlb (
    .clock        (clock),
    .reset        (reset),
    .i_wr_en      (tlb_wr_en),
    .i_wr_idx     (tlb_wr_idx),
    .i_wr_vpn     (tlb_wr_vpn),
    .i_wr_ppn     (tlb_wr_ppn),
    .i_wr_perm    (tlb_wr_perm),
    .i_inval_all  (tlb_inval_all),
    .i_lookup_vpn (e1_dcache_virt_addr_m[VA_W-1:12]),
    .o_hit        (w_hit),
    .o_multi_hit  (w_multi_hit),
    .o_ppn        (w_ppn),
    .o_perm       (w_perm)
  );

  assign e2_stall_m = r_e2.valid && dcache_e3_stall_i_s;
  assign w_accept   = e1_dcache_req_m && dcache_e1_grant_i_s && !e2_stall_m
                      && (w_opc != OPC_NOP);
  assign w_misalign = !size_legal(e1_dcache_size_m)
                      || ((w_opc == OPC_ATOMIC)
                          && ((e1_dcache_virt_addr_m[3:0] & (e1_dcache_size_m - 4'd1)) != 4'd0));

  always_comb begin
    w_trap = TRAP_NONE;
    if (w_misalign) w_trap = TRAP_DMISALIGN;
    else if (w_multi_hit) w_trap = TRAP_DSYSERROR;
    else if (!w_hit) w_trap = TRAP_NOMAPPING;
    else if (((w_opc == OPC_LOAD) && !w_perm[PERM_READ])
             || (((w_opc == OPC_STORE) || (w_opc == OPC_ATOMIC)) && !w_perm[PERM_WRITE]))
      w_trap = TRAP_PROTECTION;
    else if ((w_opc == OPC_STORE) && !w_perm[PERM_DIRTY]) w_trap = TRAP_WRITETOCLEAN;
    else if ((w_opc == OPC_ATOMIC) && !w_perm[PERM_DIRTY]) w_trap = TRAP_ATOMICTOCLEAN;
  end

  // an idle, unstalled E2 loads all zeros so the outputs need no gating
  always_comb begin
    w_e2_next = '0;
    if (e2_stall_m) begin
      w_e2_next = r_e2;
    end else if (w_accept) begin
      w_e2_next.valid = 1'b1;
      if (w_opc == OPC_PREFETCH) begin
        w_e2_next.cancel = (w_trap != TRAP_NONE);
      end else begin
        case (w_trap)
          TRAP_DMISALIGN:     w_e2_next.mis = 1'b1;
          TRAP_DSYSERROR:     w_e2_next.sys[dcache_second_acc_d_i_s]   = 1'b1;
          TRAP_NOMAPPING:     w_e2_next.nomap[dcache_second_acc_d_i_s] = 1'b1;
          TRAP_PROTECTION:    w_e2_next.prot[dcache_second_acc_d_i_s]  = 1'b1;
          TRAP_WRITETOCLEAN:  w_e2_next.w2c[dcache_second_acc_d_i_s]   = 1'b1;
          TRAP_ATOMICTOCLEAN: w_e2_next.a2c[dcache_second_acc_d_i_s]   = 1'b1;
          default:            ;
        endcase
      end
      if (w_trap == TRAP_NONE) begin
        w_e2_next.pa      = w_ppn;
        w_e2_next.policy  = w_perm[PERM_POLICY];
        w_e2_next.cluster = w_perm[PERM_CLUSTER];
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_e2 <= '0;
    else       r_e2 <= w_e2_next;
  end

  assign e2_dcache_phys_addr_m       = r_e2.pa;
  assign e2_dcache_policy_m          = r_e2.policy;
  assign e2_dcache_cluster_per_acc_m = r_e2.cluster;
  assign e2_non_trapping_id_cancel_o = r_e2.cancel;
  assign e2_trap_nomapping_o         = r_e2.nomap;
  assign e2_trap_protection_o        = r_e2.prot;
  assign e2_trap_writetoclean_o      = r_e2.w2c;
  assign e2_trap_atomictoclean_o     = r_e2.a2c;
  assign e2_trap_dsyserror_o         = r_e2.sys;
  assign e2_trap_dmisalign_o         = r_e2.mis;

endmodule

// File: doc/mmu_dcache_resp.md
# mmu_dcache_resp

MMU-side responder of the processor/D$/MMU data-access protocol. It accepts E1 data-cache requests from the processor, translates the virtual address through a small fully-associative data TLB, and drives the registered E2 response (physical page bits, policy, trap flags, stall) consumed by the processor and D$. It sits between the processor load/store unit and the D$ and is the only driver of the `e2_*` signals.

## Interface
- `TLB_ENTRIES`, 4: number of TLB entries (power of 2, 2..16).
- `VA_W`, 41: virtual address width.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `e1_dcache_req_m`  in  1  E1 request valid.
- `e1_dcache_virt_addr_m`  in  VA_W  E1 virtual address.
- `e1_dcache_size_m`  in  4  access size in bytes (1, 2, 4, 8).
- `e1_dcache_opc_i_m`  in  `e1_dcache_opc_t`  NOP=0, LOAD=1, STORE=2, ATOMIC=3, PREFETCH=4.
- `dcache_e1_grant_i_s`  in  1  D$ accepts the E1 request.
- `dcache_second_acc_d_i_s`  in  1  E1 request is second half of a D$-split access.
- `dcache_e3_stall_i_s`  in  1  D$ E3 stall; freezes E2.
- `tlb_wr_en`  in  1  TLB entry write.
- `tlb_wr_idx`  in  log2(TLB_ENTRIES)  entry index.
- `tlb_wr_vpn`  in  VA_W-12  virtual page number.
- `tlb_wr_ppn`  in  10  physical page bits [21:12].
- `tlb_wr_perm`  in  5  {cluster_per, policy, dirty, write, read}.
- `tlb_inval_all`  in  1  clear every valid bit.
- `e2_stall_m`  out  1  E2 frozen.
- `e2_dcache_phys_addr_m`  out  [21:12]  translated page bits.
- `e2_dcache_cluster_per_acc_m`, `e2_dcache_policy_m`  out  1 each  entry attributes.
- `e2_non_trapping_id_cancel_o`  out  1  PREFETCH cancelled instead of trapping.
- `e2_trap_nomapping_o`, `e2_trap_protection_o`, `e2_trap_writetoclean_o`, `e2_trap_atomictoclean_o`, `e2_trap_dsyserror_o`  out  2 each  bit0 = first access, bit1 = second access.
- `e2_trap_dmisalign_o`  out  1  atomic misalignment.

## Operation
- Accept in E1 when `e1_dcache_req_m && dcache_e1_grant_i_s && !e2_stall_m` and opc ≠ NOP; lookup is combinational in E1, result registered into E2.
- Hit: valid entry with vpn == VA[VA_W-1:12]. More than one hit → dsyserror.
- Trap evaluation, single trap, priority: dmisalign (ATOMIC with VA & (size-1) ≠ 0, or size ∉ {1,2,4,8}) > dsyserror > nomapping (miss) > protection (LOAD w/o read; STORE/ATOMIC w/o write) > writetoclean (STORE, dirty=0) / atomictoclean (ATOMIC, dirty=0).
- 2-bit traps: bit index = `dcache_second_acc_d_i_s` at acceptance.
- PREFETCH: any trap suppressed, `e2_non_trapping_id_cancel_o`=1.
- On miss or any trap: phys_addr, policy, cluster_per driven 0.
- TLB write/invalidate take effect at the next edge; a same-cycle E1 lookup sees old contents. `tlb_inval_all` with `tlb_wr_en` same cycle: invalidate wins, write dropped.

## Timing
- Reset: all TLB valid bits 0, E2 valid 0, every output 0.
- Latency: accepted at edge N → E2 outputs valid from N through the cycle before the edge at which E2 is released.
- `e2_stall_m` = E2 valid && `dcache_e3_stall_i_s` (combinational from registered state and stall input); while high, E2 register holds, no new E1 acceptance.
- No accept while not stalled: E2 valid clears next edge, all `e2_*` outputs return to 0.
- Back-to-back accepts with no stall: one request per cycle.
- Reset mid-operation: in-flight E2 discarded immediately, outputs 0 asynchronously.

## Structure
- `mmu_dcache_pkg`: `e1_dcache_opc_t`, TLB entry struct (valid, vpn, ppn, perm), perm bit positions, trap-priority constants.
- Sub-module `mmu_dcache_tlb`: entry storage, write/invalidate, parallel CAM compare returning hit, multi-hit, hit entry.
- Top: acceptance logic, trap decode, E2 pipeline register, stall.

## Test plan
- Write entry 0 vpn=0x12345, ppn=0x2A5, perm=all ones; LOAD VA=0x12345678 → next cycle phys_addr=0x2A5, policy=1, no traps.
- LOAD to unmapped VA → `e2_trap_nomapping_o`=2'b01; same with second_acc=1 → 2'b10; PREFETCH → cancel=1, traps 0.
- STORE to entry with dirty=0 → writetoclean=01; ATOMIC VA=...6 size 4 → dmisalign=1 only (priority over atomictoclean).
- Two entries same vpn; LOAD → dsyserror=01, phys_addr 0.
- Accept, then hold `dcache_e3_stall_i_s` 3 cycles → `e2_stall_m` high 3 cycles, outputs frozen, new request held until release.
- `tlb_wr_en` and `tlb_inval_all` together, then LOAD to written vpn → nomapping; assert reset during stall → all outputs 0 without a clock edge.
